// File: rtl/r200_memarb_pkg.sv
// Shared definitions for the r200 memory arbiter: FSM state encoding and
// default parameter values used by the top level and its priority selector.
package r200_memarb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_LIM_DEF = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/r200_memarb_arbprio.sv
// Combinational winner select between fetch and data requesters.
// Ports:
//   elig_i, elig_d  - requester eligibility this cycle
//   starve_cnt      - consecutive data grants taken while fetch was waiting
//   grant_i/grant_d - one-hot (or zero) grant
module r200_memarb_arbprio #(
    parameter int unsigned STARVE_LIM = 3,
    parameter int unsigned CNT_W      = $clog2(STARVE_LIM + 1)
) (
    input  logic             elig_i,
    input  logic             elig_d,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_i,
    output logic             grant_d
);

    logic starved;

    // Fetch overrides data priority only once it has been passed over STARVE_LIM times
    assign starved = (starve_cnt == CNT_W'(STARVE_LIM));
    assign grant_i = elig_i & (~elig_d | starved);
    assign grant_d = elig_d & ~grant_i;

endmodule

// File: rtl/r200_memarb.sv
// Single-port memory arbiter/sequencer: shares one external memory port
// between instruction fetch and the data stage, data-side priority with a
// starvation bound for fetch, stall generation and redirect (flush) drop.
// Ports:
//   clk, rst_n                              - clock, async active-low reset
//   if_req/if_addr/if_flush                 - fetch request, address, redirect
//   if_done/if_rdata/if_stall               - fetch completion, data, stall
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata     - data request payload
//   dm_done/dm_rdata/dm_stall               - data completion, load data, stall
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata- registered external request
//   mem_ack/mem_rdata                       - external completion and read data
module r200_memarb
    import r200_memarb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_be,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_done,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

    arb_state_e        state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
    logic              drop, drop_nxt;
    logic              if_done_nxt, dm_done_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [BE_W-1:0]   mem_be_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;

    logic elig_i, elig_d, grant_i, grant_d;

    // A requester's req is stale in its own done cycle; a redirect voids fetch
    assign elig_i = if_req & ~if_done & ~if_flush;
    assign elig_d = dm_req & ~dm_done;

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    r200_memarb_arbprio #(
        .STARVE_LIM (STARVE_LIM),
        .CNT_W      (CNT_W)
    ) u_arbprio (
        .elig_i     (elig_i),
        .elig_d     (elig_d),
        .starve_cnt (starve_cnt),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            drop       <= 1'b0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            drop       <= drop_nxt;
            if_done    <= if_done_nxt;
            dm_done    <= dm_done_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_be     <= mem_be_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        drop_nxt       = drop;
        if_done_nxt    = 1'b0;
        dm_done_nxt    = 1'b0;
        if_rdata_nxt   = if_rdata;
        dm_rdata_nxt   = dm_rdata;
        mem_we_nxt     = mem_we;
        mem_be_nxt     = mem_be;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;

        unique case (state)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_nxt     = ARB_BUSY_D;
                    mem_we_nxt    = dm_we;
                    mem_be_nxt    = dm_be;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    // Only count grants that actually made fetch wait
                    if (elig_i && (starve_cnt != CNT_W'(STARVE_LIM))) begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                end else if (grant_i) begin
                    state_nxt      = ARB_BUSY_I;
                    mem_we_nxt     = 1'b0;
                    mem_be_nxt     = '0;
                    mem_addr_nxt   = if_addr;
                    mem_wdata_nxt  = '0;
                    starve_cnt_nxt = '0;
                end
            end
            ARB_BUSY_I: begin
                if (if_flush) begin
                    drop_nxt = 1'b1;
                end
                if (mem_ack) begin
                    state_nxt = ARB_IDLE;
                    drop_nxt  = 1'b0;
                    // A redirect in the ack cycle also discards the result
                    if (!drop && !if_flush) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end
            end
            ARB_BUSY_D: begin
                if (mem_ack) begin
                    state_nxt   = ARB_IDLE;
                    dm_done_nxt = 1'b1;
                    if (!mem_we) begin
                        dm_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase

        mem_req_nxt = (state_nxt != ARB_IDLE);
    end

endmodule

// File: tb/tb_r200_memarb.sv
// Self-checking bench for r200_memarb: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_r200_memarb;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 4;
    localparam int unsigned LIM = 3;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [BW-1:0] dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    r200_memarb #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (LIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_be     = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if ({mem_req, mem_we, mem_be, if_done, dm_done, if_stall, dm_stall} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {mem_req, mem_we, mem_be, if_done, dm_done, if_stall, dm_stall});
        end
        checks++;
        if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {if_rdata, dm_rdata, mem_addr, mem_wdata});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: mem_req got %b expected 0", mem_req);
        end
    endtask

    task automatic test_lone_fetch();
        if_req  = 1'b1;
        if_addr = 32'h40;
        step();
        checks++;
        if ({mem_req, mem_we, mem_be, if_stall} !== {1'b1, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL lone_fetch_grant: got %b expected 1000001", {mem_req, mem_we, mem_be, if_stall});
        end
        checks++;
        if (mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL lone_fetch_addr: got %h expected 00000040", mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h00500093;
        step();
        checks++;
        if ({if_done, if_stall, mem_req, mem_we} !== 4'b1000) begin
            errors++;
            $display("FAIL lone_fetch_done: got %b expected 1000", {if_done, if_stall, mem_req, mem_we});
        end
        checks++;
        if (if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL lone_fetch_rdata: got %h expected 00500093", if_rdata);
        end
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();
        checks++;
        if (if_done !== 1'b0) begin
            errors++;
            $display("FAIL lone_fetch_pulse: if_done got %b expected 0", if_done);
        end
    endtask

    task automatic test_wait_states();
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_be    = 4'h3;
        dm_addr  = 32'h208;
        dm_wdata = 32'h55AA55AA;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mem_req, dm_stall, dm_done, mem_we} !== 4'b1100) begin
                errors++;
                $display("FAIL wait_ctrl[%0d]: got %b expected 1100", i, {mem_req, dm_stall, dm_done, mem_we});
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_be} !== {32'h208, 32'h55AA55AA, 4'h3}) begin
                errors++;
                $display("FAIL wait_fields[%0d]: got %h expected 0000020855aa55aa3", i,
                         {mem_addr, mem_wdata, mem_be});
            end
            mem_ack   = (i == 4);
            mem_rdata = (i == 4) ? 32'hCAFEF00D : 32'h0BADBAD0;
            step();
        end
        checks++;
        if ({dm_done, dm_stall, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL wait_done: got %b expected 100", {dm_done, dm_stall, mem_req});
        end
        checks++;
        if (dm_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wait_rdata: got %h expected cafef00d", dm_rdata);
        end
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_store_then_fetch();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h100;
        dm_wdata = 32'hDEADBEEF;
        dm_be    = 4'hF;
        if_req   = 1'b1;
        if_addr  = 32'h44;
        step();
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'b111111) begin
            errors++;
            $display("FAIL store_grant: got %b expected 111111", {mem_req, mem_we, mem_be});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL store_fields: got %h expected 00000100deadbeef", {mem_addr, mem_wdata});
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        checks++;
        if ({dm_done, dm_stall, if_stall, mem_req} !== 4'b1010) begin
            errors++;
            $display("FAIL store_done: got %b expected 1010", {dm_done, dm_stall, if_stall, mem_req});
        end
        checks++;
        if (dm_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL store_rdata_hold: got %h expected cafef00d", dm_rdata);
        end
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'b100000 || mem_addr !== 32'h44) begin
            errors++;
            $display("FAIL b2b_fetch_grant: got %b addr %h expected 100000 addr 00000044",
                     {mem_req, mem_we, mem_be}, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h00000013;
        step();
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h13) begin
            errors++;
            $display("FAIL b2b_fetch_done: got %b/%h expected 1/00000013", if_done, if_rdata);
        end
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_flush();
        if_req  = 1'b1;
        if_addr = 32'h40;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mem_req, if_done} !== 2'b10 || mem_addr !== 32'h40) begin
                errors++;
                $display("FAIL flush_busy[%0d]: got %b addr %h expected 10 addr 00000040", i,
                         {mem_req, if_done}, mem_addr);
            end
            if_flush  = (i == 1);
            if (i == 1) if_addr = 32'h80;
            mem_ack   = (i == 4);
            mem_rdata = 32'hBADC0DE0;
            step();
        end
        checks++;
        if ({if_done, if_stall, mem_req} !== 3'b010) begin
            errors++;
            $display("FAIL flush_dropped: got %b expected 010", {if_done, if_stall, mem_req});
        end
        checks++;
        if (if_rdata !== 32'h13) begin
            errors++;
            $display("FAIL flush_rdata_hold: got %h expected 00000013", if_rdata);
        end
        mem_ack = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL refetch_grant: got %b addr %h expected 1 addr 00000080", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h00A00113;
        step();
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h00A00113) begin
            errors++;
            $display("FAIL refetch_done: got %b/%h expected 1/00a00113", if_done, if_rdata);
        end
        // next fetch, redirected exactly in its ack cycle
        mem_ack = 1'b0;
        if_addr = 32'hC0;
        step();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stale_req_ignored: mem_req got %b expected 0", mem_req);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin
            errors++;
            $display("FAIL ackflush_grant: got %b addr %h expected 1 addr 000000c0", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        if_flush  = 1'b1;
        mem_rdata = 32'hFFFF0000;
        step();
        checks++;
        if (if_done !== 1'b0 || if_rdata !== 32'h00A00113 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ackflush_drop: got %b/%h/%b expected 0/00a00113/0", if_done, if_rdata, mem_req);
        end
        if_req   = 1'b0;
        if_flush = 1'b0;
        mem_ack  = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        // fetch is redirected in every data done cycle so it keeps losing
        bit exp_i [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
        int ng = 0;
        bit prev_req = 1'b0;
        do_reset();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        if_req  = 1'b1;
        if_addr = 32'h300;
        for (int c = 0; c < 80 && ng < 9; c++) begin
            step();
            if (mem_req && !prev_req) begin
                checks++;
                if ((mem_addr == 32'h300) !== exp_i[ng]) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: got fetch=%b expected fetch=%b", ng,
                             (mem_addr == 32'h300), exp_i[ng]);
                end
                ng++;
            end
            prev_req = mem_req;
            mem_ack  = mem_req;
            if_flush = dm_done;
        end
        checks++;
        if (ng != 9) begin
            errors++;
            $display("FAIL starve_timeout: got %0d grants expected 9", ng);
        end
        if_req   = 1'b0;
        dm_req   = 1'b0;
        if_flush = 1'b0;
        mem_ack  = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'hF;
        dm_addr  = 32'h10;
        dm_wdata = 32'h1234;
        step();
        checks++;
        if (mem_req !== 1'b1 || dm_stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: got %b%b expected 11", mem_req, dm_stall);
        end
        #2;
        rst_n  = 1'b0;
        dm_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, dm_done, dm_stall} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected 000", {mem_req, dm_done, dm_stall});
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({mem_req, dm_done, if_done} !== 3'b000 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_nodone: got %b/%h expected 000/00000000", {mem_req, dm_done, if_done}, dm_rdata);
        end
        mem_ack = 1'b0;
        step();
        checks++;
        if ({mem_req, dm_done, if_done} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_idle: got %b expected 000", {mem_req, dm_done, if_done});
        end
    endtask

    task automatic test_random();
        // reference: owner 0 = none, 1 = fetch, 2 = data
        int unsigned   owner, passes, wait_left;
        bit            drop_res, i_done, d_done, e_i, e_d, win_i;
        logic [DW-1:0] i_data, d_data, q_wdata;
        logic [AW-1:0] q_addr;
        bit            q_we;
        logic [BW-1:0] q_be;
        do_reset();
        owner = 0; passes = 0; wait_left = 0;
        drop_res = 0; i_done = 0; d_done = 0;
        i_data = '0; d_data = '0; q_wdata = '0; q_addr = '0; q_we = 0; q_be = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!if_req || i_done) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = {$urandom} & 32'hFFFF_FFFC;
            end
            if_flush = ($urandom_range(0, 9) == 0);
            if (if_flush && if_req) if_addr = {$urandom} & 32'hFFFF_FFFC;
            if (!dm_req || d_done) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = 1'($urandom);
                dm_be    = BW'($urandom);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            if (owner != 0) begin
                mem_ack = (wait_left == 0);
                if (wait_left != 0) wait_left--;
            end else begin
                mem_ack = ($urandom_range(0, 5) == 0);
            end
            mem_rdata = $urandom;

            e_i = if_req && !i_done && !if_flush;
            e_d = dm_req && !d_done;
            i_done = 0;
            d_done = 0;
            if (owner == 0) begin
                win_i = e_i && (!e_d || passes == LIM);
                if (e_d && !win_i) begin
                    owner = 2; q_addr = dm_addr; q_we = dm_we; q_be = dm_be; q_wdata = dm_wdata;
                    if (e_i && passes < LIM) passes++;
                    wait_left = $urandom_range(0, 3);
                end else if (win_i) begin
                    owner = 1; q_addr = if_addr; q_we = 0; q_be = '0;
                    passes = 0;
                    wait_left = $urandom_range(0, 3);
                end
            end else if (owner == 1) begin
                if (if_flush) drop_res = 1;
                if (mem_ack) begin
                    if (!drop_res) begin i_done = 1; i_data = mem_rdata; end
                    drop_res = 0;
                    owner = 0;
                end
            end else if (mem_ack) begin
                d_done = 1;
                if (!q_we) d_data = mem_rdata;
                owner = 0;
            end

            step();
            checks++;
            if ({mem_req, if_done, dm_done} !== {owner != 0, i_done, d_done}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got %b expected %b", n, {mem_req, if_done, dm_done},
                         {owner != 0, i_done, d_done});
            end
            checks++;
            if ({if_stall, dm_stall} !== {if_req && !i_done, dm_req && !d_done}) begin
                errors++;
                $display("FAIL rand_stall[%0d]: got %b%b expected %b%b", n, if_stall, dm_stall,
                         if_req && !i_done, dm_req && !d_done);
            end
            checks++;
            if (if_rdata !== i_data || dm_rdata !== d_data) begin
                errors++;
                $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", n, if_rdata, dm_rdata, i_data, d_data);
            end
            if (owner != 0) begin
                checks++;
                if (mem_addr !== q_addr || mem_we !== q_we || mem_be !== q_be) begin
                    errors++;
                    $display("FAIL rand_fields[%0d]: got %h/%b/%h expected %h/%b/%h", n,
                             mem_addr, mem_we, mem_be, q_addr, q_we, q_be);
                end
            end
            if (owner == 2) begin
                checks++;
                if (mem_wdata !== q_wdata) begin
                    errors++;
                    $display("FAIL rand_wdata[%0d]: got %h expected %h", n, mem_wdata, q_wdata);
                end
            end
        end
        idle_inputs();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_wait_states();
        test_store_then_fetch();
        test_flush();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
